// File: rtl/param_bist_engine.sv
// param_bist_engine
//   Parametrised built-in self-test engine. An LFSR generates NUM_PAT
//   patterns for an external circuit-under-test (CUT). A MISR compacts the
//   CUT responses into a signature, which is compared against a golden value.
//
// Handshake (valid/Ready):
//   The controller raises valid and holds it high for the whole run. Ready
//   rises once NUM_PAT responses have been compacted, and pass is then
//   meaningful. Ready and pass stay high until the controller drops valid.
//   Dropping valid before Ready aborts the run, and the engine returns to IDLE.
//
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   valid      - run request (level)
//   seed_load  - capture seed into the seed register (honoured in IDLE only)
//   seed       - seed value
//   golden     - expected signature
//   cut_in     - pattern to the CUT (LFSR register)
//   cut_out    - CUT response
//   Result     - running signature (MISR register)
//   sig_valid  - one-cycle strobe after each compaction
//   pat_cnt    - compactions done this run
//   Ready      - run complete (level)
//   pass       - signature matched golden (meaningful while Ready=1)
//   state_dbg  - FSM state (0 IDLE, 1 RUN, 2 DONE)
module param_bist_engine #(
   parameter int               PAT_W     = 8,
   parameter int               SIG_W     = 10,
   parameter int               NUM_PAT   = 255,
   parameter logic [PAT_W-1:0] LFSR_TAPS = 8'hB8,
   parameter logic [SIG_W-1:0] MISR_TAPS = 10'h240,
   parameter logic [PAT_W-1:0] SEED      = 1,
   parameter int               CUT_LAT   = 0,
   localparam int              CNT_W     = $clog2(NUM_PAT + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic             seed_load,
   input  logic [PAT_W-1:0] seed,
   input  logic [SIG_W-1:0] golden,
   output logic [PAT_W-1:0] cut_in,
   input  logic [SIG_W-1:0] cut_out,
   output logic [SIG_W-1:0] Result,
   output logic             sig_valid,
   output logic [CNT_W-1:0] pat_cnt,
   output logic             Ready,
   output logic             pass,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [PAT_W-1:0] lfsr, lfsr_nxt, seed_reg, seed_eff;
   logic [SIG_W-1:0] misr, misr_nxt;
   logic [CNT_W-1:0] issue_cnt;
   logic             run_act, issue, cmp_flag, cmp, last_cmp;

   // An all-zero seed would lock the LFSR, so it is replaced with 1.
   assign seed_eff = (seed_reg == '0) ? PAT_W'(1) : seed_reg;
   assign lfsr_nxt = {lfsr[PAT_W-2:0], ^(lfsr & LFSR_TAPS)};
   assign misr_nxt = {misr[SIG_W-2:0], ^(misr & MISR_TAPS)} ^ cut_out;

   // An abort (valid low in RUN) takes priority over any stepping on that edge.
   assign run_act  = (state == RUN) && valid;
   assign issue    = run_act && (issue_cnt < CNT_W'(NUM_PAT));

   // The issue flag is delayed by the CUT latency. A set delayed flag marks
   // the cycle in which cut_out carries the response to an issued pattern.
   generate
      if (CUT_LAT == 0) begin : g_no_lat
         assign cmp_flag = issue;
      end else begin : g_lat
         logic [CUT_LAT-1:0] dly;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       dly <= '0;
            else if (run_act) dly <= (dly << 1) | CUT_LAT'(issue);
            else              dly <= '0;
         end
         assign cmp_flag = dly[CUT_LAT-1];
      end
   endgenerate

   assign cmp      = run_act && cmp_flag;
   assign last_cmp = cmp && (pat_cnt == CNT_W'(NUM_PAT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid) state_nxt = RUN;
         RUN: begin
            if (!valid)        state_nxt = IDLE;
            else if (last_cmp) state_nxt = DONE;
         end
         DONE:    if (!valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr      <= '0;
         misr      <= '0;
         issue_cnt <= '0;
         pat_cnt   <= '0;
         sig_valid <= 1'b0;
         Ready     <= 1'b0;
         pass      <= 1'b0;
         seed_reg  <= SEED;
      end else begin
         sig_valid <= 1'b0;
         case (state)
            IDLE: begin
               Ready <= 1'b0;
               pass  <= 1'b0;
               if (seed_load) seed_reg <= seed;
               // seed_eff still reflects the old seed register on this edge.
               if (valid) begin
                  lfsr      <= seed_eff;
                  misr      <= '0;
                  issue_cnt <= '0;
                  pat_cnt   <= '0;
               end
            end
            RUN: begin
               if (issue) begin
                  lfsr      <= lfsr_nxt;
                  issue_cnt <= issue_cnt + 1'b1;
               end
               if (cmp) begin
                  misr      <= misr_nxt;
                  sig_valid <= 1'b1;
                  if (pat_cnt < CNT_W'(NUM_PAT)) pat_cnt <= pat_cnt + 1'b1;
               end
               // The verdict uses the signature produced by this final compaction.
               if (last_cmp) begin
                  Ready <= 1'b1;
                  pass  <= (misr_nxt == golden);
               end
            end
            DONE: begin
               if (!valid) begin
                  Ready <= 1'b0;
                  pass  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign cut_in    = lfsr;
   assign Result    = misr;
   assign state_dbg = state;

endmodule

// File: tb/tb_param_bist_engine.sv
// Testbench for param_bist_engine. Three instances are used:
//   dut0 - 4-bit, NUM_PAT=3, CUT_LAT=0, identity CUT
//   dut1 - same, CUT_LAT=2, two-register CUT pipeline
//   dut2 - 4-bit, NUM_PAT=15, used for the full LFSR sequence
module tb_param_bist_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid, seed_load, valid2;
   logic [3:0] seed, golden;

   logic [3:0] cut_in0, Result0, cut_in1, Result1, cut_out1, p1, p2;
   logic [3:0] cut_in2, Result2;
   logic       sig_valid0, Ready0, pass0, sig_valid1, Ready1, pass1;
   logic       sig_valid2, Ready2, pass2;
   logic [1:0] pat_cnt0, pat_cnt1, state_dbg0, state_dbg1, state_dbg2;
   logic [3:0] pat_cnt2;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] exp0_q[$];
   logic [3:0] exp1_q[$];
   logic [3:0] pat2_q[$];

   always #5 clk = ~clk;

   param_bist_engine #(.PAT_W(4), .SIG_W(4), .NUM_PAT(3), .LFSR_TAPS(4'hC),
                       .MISR_TAPS(4'hC), .SEED(4'h1), .CUT_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .valid(valid), .seed_load(seed_load),
      .seed(seed), .golden(golden), .cut_in(cut_in0), .cut_out(cut_in0),
      .Result(Result0), .sig_valid(sig_valid0), .pat_cnt(pat_cnt0),
      .Ready(Ready0), .pass(pass0), .state_dbg(state_dbg0));

   param_bist_engine #(.PAT_W(4), .SIG_W(4), .NUM_PAT(3), .LFSR_TAPS(4'hC),
                       .MISR_TAPS(4'hC), .SEED(4'h1), .CUT_LAT(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .valid(valid), .seed_load(seed_load),
      .seed(seed), .golden(golden), .cut_in(cut_in1), .cut_out(cut_out1),
      .Result(Result1), .sig_valid(sig_valid1), .pat_cnt(pat_cnt1),
      .Ready(Ready1), .pass(pass1), .state_dbg(state_dbg1));

   param_bist_engine #(.PAT_W(4), .SIG_W(4), .NUM_PAT(15), .LFSR_TAPS(4'hC),
                       .MISR_TAPS(4'hC), .SEED(4'h1), .CUT_LAT(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .valid(valid2), .seed_load(1'b0),
      .seed(4'h0), .golden(4'h0), .cut_in(cut_in2), .cut_out(4'h0),
      .Result(Result2), .sig_valid(sig_valid2), .pat_cnt(pat_cnt2),
      .Ready(Ready2), .pass(pass2), .state_dbg(state_dbg2));

   // Two-stage registered CUT for dut1
   always @(posedge clk) begin
      p1 <= cut_in1;
      p2 <= p1;
   end
   assign cut_out1 = p2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_both_full();
      exp0_q.push_back(4'h1); exp0_q.push_back(4'h0); exp0_q.push_back(4'h4);
      exp1_q.push_back(4'h1); exp1_q.push_back(4'h0); exp1_q.push_back(4'h4);
   endtask

   // Monitors: pop and compare whenever a DUT presents an output
   always @(negedge clk) begin
      if (sig_valid0) begin
         if (exp0_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL dut0 strobe: got unexpected sig_valid with Result %0h", Result0);
         end else check("dut0 Result", 32'(Result0), 32'(exp0_q.pop_front()));
      end
      if (sig_valid1) begin
         if (exp1_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL dut1 strobe: got unexpected sig_valid with Result %0h", Result1);
         end else check("dut1 Result", 32'(Result1), 32'(exp1_q.pop_front()));
      end
      if (state_dbg2 == 2'd1) begin
         if (pat2_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL dut2 pattern: got extra RUN cycle with cut_in %0h", cut_in2);
         end else check("dut2 cut_in", 32'(cut_in2), 32'(pat2_q.pop_front()));
      end
   end

   initial begin
      #100000;
      n_checks++; n_errors++;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      logic [3:0] seq [15];
      seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
              4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
      rst_n = 1'b0; valid = 1'b0; valid2 = 1'b0; seed_load = 1'b0;
      seed = 4'h0; golden = 4'h0;
      #3;
      check("reset cut_in", 32'(cut_in0), 0);
      check("reset Result", 32'(Result0), 0);
      check("reset sig_valid", 32'(sig_valid0), 0);
      check("reset pat_cnt", 32'(pat_cnt0), 0);
      check("reset Ready", 32'(Ready0), 0);
      check("reset pass", 32'(pass0), 0);
      check("reset state", 32'(state_dbg0), 0);
      #10 rst_n = 1'b1;
      tick(); tick();

      // Run A: golden matches, hold valid in DONE
      golden = 4'h4; push_both_full();
      valid = 1'b1;
      tick();
      check("A cut_in cycle0 default seed", 32'(cut_in0), 1);
      tick(); tick();
      check("A dut0 Ready early", 32'(Ready0), 0);
      tick();
      check("A dut0 Ready", 32'(Ready0), 1);
      check("A dut0 pass", 32'(pass0), 1);
      check("A dut0 pat_cnt", 32'(pat_cnt0), 3);
      check("A dut0 Result", 32'(Result0), 4);
      tick();
      check("A dut1 Ready early", 32'(Ready1), 0);
      tick();
      check("A dut1 Ready", 32'(Ready1), 1);
      check("A dut1 pass", 32'(pass1), 1);
      check("A dut1 Result", 32'(Result1), 4);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("A hold Ready", 32'(Ready0), 1);
         check("A hold pass", 32'(pass0), 1);
         check("A hold dut1 Ready", 32'(Ready1), 1);
      end
      valid = 1'b0;
      tick();
      check("A Ready cleared", 32'(Ready0), 0);
      check("A pass cleared", 32'(pass0), 0);
      check("A state idle", 32'(state_dbg0), 0);

      // Run B: seed 0 acts as 1, golden mismatch, seed_load ignored in RUN
      seed = 4'h0; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      golden = 4'h5; push_both_full();
      valid = 1'b1;
      tick();
      check("B cut_in cycle0 seed0", 32'(cut_in0), 1);
      seed = 4'h8; seed_load = 1'b1;
      tick(); tick();
      seed_load = 1'b0;
      tick();
      check("B dut0 Ready", 32'(Ready0), 1);
      check("B dut0 pass", 32'(pass0), 0);
      check("B dut0 Result", 32'(Result0), 4);
      tick(); tick();
      check("B dut1 Ready", 32'(Ready1), 1);
      check("B dut1 pass", 32'(pass1), 0);
      valid = 1'b0;
      tick();

      // Run C: abort in the third RUN cycle
      golden = 4'h4;
      exp0_q.push_back(4'h1); exp0_q.push_back(4'h0);
      valid = 1'b1;
      tick();
      check("C cut_in seed unchanged", 32'(cut_in0), 1);
      tick(); tick();
      valid = 1'b0;
      tick();
      check("C dut0 state idle", 32'(state_dbg0), 0);
      check("C dut1 state idle", 32'(state_dbg1), 0);
      check("C sig_valid low", 32'(sig_valid0), 0);
      check("C Ready low", 32'(Ready0), 0);
      repeat (3) tick();
      check("C Ready stays low", 32'(Ready0), 0);
      check("C dut1 Ready stays low", 32'(Ready1), 0);

      // Run D: restart after abort
      push_both_full();
      valid = 1'b1;
      tick();
      repeat (3) tick();
      check("D dut0 Result", 32'(Result0), 4);
      check("D dut0 pass", 32'(pass0), 1);
      tick(); tick();
      check("D dut1 Result", 32'(Result1), 4);
      check("D dut1 pass", 32'(pass1), 1);
      valid = 1'b0;
      tick();

      // Run E: asynchronous reset mid-RUN, seed register returns to SEED
      seed = 4'h3; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      exp0_q.push_back(4'h3);
      valid = 1'b1;
      tick();
      check("E cut_in seed 3", 32'(cut_in0), 3);
      tick();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("E rst cut_in", 32'(cut_in0), 0);
      check("E rst Result", 32'(Result0), 0);
      check("E rst sig_valid", 32'(sig_valid0), 0);
      check("E rst pat_cnt", 32'(pat_cnt0), 0);
      check("E rst state", 32'(state_dbg0), 0);
      check("E rst dut1 state", 32'(state_dbg1), 0);
      valid = 1'b0;
      #3 rst_n = 1'b1;
      tick();
      push_both_full();
      valid = 1'b1;
      tick();
      check("E cut_in seed reset", 32'(cut_in0), 1);
      repeat (3) tick();
      check("E dut0 Ready", 32'(Ready0), 1);
      check("E dut0 Result", 32'(Result0), 4);
      tick(); tick();
      check("E dut1 Ready", 32'(Ready1), 1);
      valid = 1'b0;
      tick();

      // Run F: full 15-pattern LFSR sequence on dut2
      for (int i = 0; i < 15; i++) pat2_q.push_back(seq[i]);
      valid2 = 1'b1;
      tick();
      repeat (15) tick();
      check("F dut2 Ready", 32'(Ready2), 1);
      check("F dut2 pat_cnt", 32'(pat_cnt2), 15);
      check("F dut2 pass", 32'(pass2), 1);
      check("F dut2 lfsr wrapped", 32'(cut_in2), 1);
      valid2 = 1'b0;
      tick();
      check("F dut2 Ready cleared", 32'(Ready2), 0);

      tick(); tick();
      check("dut0 queue drained", exp0_q.size(), 0);
      check("dut1 queue drained", exp1_q.size(), 0);
      check("dut2 queue drained", pat2_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/param_bist_engine.md
Name: param_bist_engine

Overview:
Parametrised built-in self-test engine: LFSR pattern generator drives an external circuit-under-test (CUT), and a MISR compacts its responses into a signature compared against a golden value. Successor to the fixed 10-bit adder BIST top, generalised in pattern width, signature width, pattern count, polynomials and CUT pipeline latency, and adding a programmable seed, abort and a pass/fail verdict. Sits between the test controller/testbench (valid/Ready handshake) and the CUT.

Parameters:
PAT_W, 8, LFSR/pattern width (>=2)
SIG_W, 10, MISR/signature width (>=2)
NUM_PAT, 255, patterns applied per run (>=1)
LFSR_TAPS, 8'hB8, LFSR feedback mask (PAT_W bits)
MISR_TAPS, 10'h240, MISR feedback mask (SIG_W bits)
SEED, 1, reset value of seed register
CUT_LAT, 0, CUT response latency in cycles (0 = combinational)
CNT_W, $clog2(NUM_PAT+1), derived localparam, counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
valid  in  1  run request; level, held high for whole run
seed_load  in  1  capture seed into seed register (IDLE only)
seed  in  PAT_W  seed value
golden  in  SIG_W  expected signature
cut_in  out  PAT_W  pattern to CUT (= LFSR register)
cut_out  in  SIG_W  CUT response
Result  out  SIG_W  running signature (= MISR register)
sig_valid  out  1  one-cycle strobe after each compaction
pat_cnt  out  CNT_W  compactions done this run
Ready  out  1  run complete; level
pass  out  1  signature matched golden; meaningful only while Ready=1

Behaviour:
- Reset (async, any state): state IDLE; lfsr, misr, counters, delay line, sig_valid, Ready, pass = 0; seed register = SEED.
- seed_eff = (seed_reg == 0) ? 1 : seed_reg (lock-up avoidance).
- LFSR step: lfsr <= {lfsr[PAT_W-2:0], ^(lfsr & LFSR_TAPS)}.
- MISR step: misr <= {misr[SIG_W-2:0], ^(misr & MISR_TAPS)} ^ cut_out.
- FSM states IDLE, RUN, DONE.
- IDLE: Ready=0, pass=0. seed_load=1 captures seed (seed_load ignored in RUN/DONE). Edge with valid=1 -> RUN; lfsr<=seed_eff, misr<=0, issue_cnt<=0, pat_cnt<=0, delay line cleared. If valid and seed_load are both high, seed_eff uses the old seed register value.
- RUN, per edge:
  - If issue_cnt < NUM_PAT: advance LFSR, issue_cnt++, push 1 into a CUT_LAT-deep issue delay line; else push 0.
  - Pattern k is on cut_in during RUN cycle k (k = 0..NUM_PAT-1). Its response is compacted at the end of cycle k+CUT_LAT, when the delayed issue flag = 1. On that edge: MISR step, pat_cnt++, sig_valid<=1; otherwise sig_valid<=0.
  - The edge performing compaction number NUM_PAT -> DONE.
  - Total RUN duration = NUM_PAT+CUT_LAT cycles.
- DONE: Ready=1 and pass = (misr == golden), both registered on the DONE-entry edge using golden at that edge. lfsr/misr hold; sig_valid=0. Stays until valid=0, then -> IDLE, where Ready and pass clear on that edge.
- Abort: valid=0 in RUN -> IDLE on next edge; sig_valid=0, Ready stays 0; misr/lfsr hold until the next start re-initialises them.
- pat_cnt saturates at NUM_PAT; no wrap. LFSR stops after NUM_PAT issues.
- Reset during RUN/DONE: immediate return to reset values, including the seed register.

Test Plan:
- PAT_W=4, LFSR_TAPS=4'hC, seed 1, NUM_PAT=15 -> cut_in sequence 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8 in successive RUN cycles.
- SIG_W=4, MISR_TAPS=4'hC, NUM_PAT=3, CUT_LAT=0, identity CUT (cut_out=cut_in) -> Result 1,0,4; sig_valid 3 strobes; Ready rises 3 cycles after RUN entry. golden=4 -> pass=1; golden=5 -> pass=0.
- Same config, CUT_LAT=2, CUT = 2-stage register pipeline -> final Result 4, Ready 5 cycles after RUN entry, pass=1.
- seed_load with seed=0 -> run identical to seed=1; default reset seed = SEED; seed_load asserted during RUN -> seed register unchanged.
- Drop valid in the 3rd RUN cycle -> IDLE next edge, Ready never rises, sig_valid low. Restart -> signature identical to an uninterrupted run.
- Assert rst_n=0 mid-RUN (asynchronously, between edges) -> all outputs 0 immediately, state IDLE. Hold valid in DONE for 10 cycles -> Ready/pass stable; drop valid -> Ready=0 next edge.
